// File: rtl/uart_pkg.sv
// Shared types and constants for the UART TX arbiter slice.
package uart_pkg;

   // Upper bound on the number of requesters one arbiter instance may serve.
   localparam int unsigned UART_ARB_MAX_REQ = 16;

   // Arbiter sequencing: wait for a request, stream one grant, optional idle gap.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: first set request strictly after ptr, wrapping modulo N.
module rr_pick #(
   parameter int unsigned N = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   // Walk ptr+1 .. ptr+N; the first hit wins, ptr itself is checked last.
   always_comb begin
      int unsigned j;
      found = 1'b0;
      idx   = '0;
      j     = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!found && req[IW'(j)]) begin
            found = 1'b1;
            idx   = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART TX byte sink among N_REQ sources.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned N_BITS     = 8,
   parameter int unsigned MAX_BURST  = 16,
   parameter int unsigned GAP_CYCLES = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*N_BITS-1:0]   req_data,
   input  logic [N_REQ-1:0]          req_last,
   output logic [N_REQ-1:0]          req_ready,
   output logic                      tx_valid,
   output logic [N_BITS-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [$clog2(N_REQ)-1:0]  grant_id,
   output logic                      grant_active
);

   localparam int unsigned IW       = $clog2(N_REQ);
   localparam int unsigned BW       = $clog2(MAX_BURST + 1);
   localparam int unsigned GW       = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   arb_state_t    state_q, state_d;
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [IW-1:0] grant_id_q, grant_id_d;
   logic [BW-1:0] beat_cnt_q, beat_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;

   logic          pick_found;
   logic [IW-1:0] pick_idx;
   logic          beat_c;
   logic          release_c;

   rr_pick #(.N(N_REQ)) u_rr_pick (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // A beat is a handshake with the granted source; release on its last byte or burst cap.
   always_comb begin
      beat_c    = (state_q == XFER) && req_valid[grant_id_q] && tx_ready;
      release_c = beat_c && (req_last[grant_id_q] || (beat_cnt_q == BW'(MAX_BURST - 1)));
   end

   // State and arbitration registers; synchronous reset drops any grant in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rr_ptr_q   <= IW'(N_REQ - 1);
         grant_id_q <= '0;
         beat_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         beat_cnt_q <= beat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
      end
   end

   // Next-state and counter update logic.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      beat_cnt_d = beat_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_id_d = pick_idx;
               beat_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            if (beat_c) begin
               beat_cnt_d = beat_cnt_q + BW'(1);
            end
            if (release_c) begin
               rr_ptr_d = grant_id_q;
               if (GAP_CYCLES > 0) begin
                  gap_cnt_d = '0;
                  state_d   = GAP;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q + GW'(1);
            if (gap_cnt_q == GW'(GAP_LAST)) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Combinational pass-through of the granted source; nothing is accepted while rst is high.
   always_comb begin
      req_ready    = '0;
      tx_valid     = 1'b0;
      tx_data      = '0;
      grant_active = 1'b0;
      grant_id     = grant_id_q;
      if (state_q == XFER) begin
         grant_active = 1'b1;
         tx_data      = req_data[32'(grant_id_q) * N_BITS +: N_BITS];
         if (!rst) begin
            tx_valid              = req_valid[grant_id_q];
            req_ready[grant_id_q] = tx_ready;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed packets, in-order expected beats.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // Main DUT: MAX_BURST=4, no gap.
   logic        rst;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data  = '0;
   logic [3:0]  req_last  = '0;
   logic [3:0]  req_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;
   logic [1:0]  grant_id;
   logic        grant_active;

   // Second DUT: GAP_CYCLES=3.
   logic        rst2;
   logic [3:0]  req_valid2;
   logic [31:0] req_data2;
   logic [3:0]  req_last2;
   logic [3:0]  req_ready2;
   logic        tx_valid2;
   logic [7:0]  tx_data2;
   logic        tx_ready2;
   logic [1:0]  grant_id2;
   logic        grant_active2;

   uart_tx_arbiter #(.N_REQ(4), .N_BITS(8), .MAX_BURST(4), .GAP_CYCLES(0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant_id(grant_id), .grant_active(grant_active)
   );

   uart_tx_arbiter #(.N_REQ(4), .N_BITS(8), .MAX_BURST(16), .GAP_CYCLES(3)) dut_gap (
      .clk(clk), .rst(rst2), .req_valid(req_valid2), .req_data(req_data2), .req_last(req_last2),
      .req_ready(req_ready2), .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
      .grant_id(grant_id2), .grant_active(grant_active2)
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [8:0]  pq [4][$];
   logic [9:0]  exp_q[$];
   int          beat_cyc[$];
   logic [3:0]  fire = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic load(input int r, input logic [7:0] d, input logic l);
      pq[r].push_back({l, d});
   endtask

   task automatic expect_beat(input logic [1:0] id, input logic [7:0] d);
      exp_q.push_back({id, d});
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < 4; i++) s += pq[i].size();
      return s;
   endfunction

   task automatic wait_drain(input string name, input int max_cyc);
      int n = 0;
      while ((exp_q.size() != 0 || pending() != 0) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drained"}, 32'(exp_q.size() + pending()), 32'd0);
   endtask

   task automatic wait_tx(input string name, input logic [7:0] d, input int max_cyc);
      int n = 0;
      while (!(tx_valid === 1'b1 && tx_data === d) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      check({name, "_seen"}, 32'(tx_data), 32'(d));
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every beat presented to the sink is matched against the scoreboard head.
   always @(negedge clk) begin
      logic [9:0] e;
      fire = req_valid & req_ready;
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         beat_cyc.push_back(cyc);
         check("req_ready_onehot", 32'(req_ready), 32'(4'b0001 << grant_id));
         if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(tx_data), 32'(e[7:0]));
            check("grant_id", 32'(grant_id), 32'(e[9:8]));
         end
      end
   end

   // Producers: each source presents its queue head and retires it after a handshake.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < 4; i++) begin
         if (fire[i] === 1'b1 && pq[i].size() > 0) void'(pq[i].pop_front());
         if (pq[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_data[i*8 +: 8]  = pq[i][0][7:0];
            req_last[i]         = pq[i][0][8];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[i*8 +: 8]  = 8'h00;
            req_last[i]         = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [11:0] ga_pat;
      rst = 1'b1; tx_ready = 1'b1;
      rst2 = 1'b1; req_valid2 = '0; req_data2 = '0; req_last2 = '0; tx_ready2 = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_grant_active", 32'(grant_active), 32'd0);
      check("rst_grant_id", 32'(grant_id), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1; rst = 1'b0; rst2 = 1'b0;

      // 1) single source, three-byte packet, one-cycle grant latency
      @(negedge clk);
      load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0); load(0, 8'hA3, 1'b1);
      expect_beat(2'd0, 8'hA1); expect_beat(2'd0, 8'hA2); expect_beat(2'd0, 8'hA3);
      @(negedge clk);
      check("t1_req_valid_up", 32'(req_valid), 32'h1);
      check("t1_latency_pre", 32'(tx_valid), 32'd0);
      @(negedge clk);
      check("t1_latency_post", 32'(tx_valid), 32'd1);
      check("t1_grant_active", 32'(grant_active), 32'd1);
      wait_drain("t1", 50);
      check("t1_released", 32'(grant_active), 32'd0);

      // 2) all four sources with 1-byte packets: rotation continues from last holder (0)
      beat_cyc.delete();
      for (int i = 0; i < 4; i++) begin
         load(i, 8'h10 + 8'(i), 1'b1);
         load(i, 8'h20 + 8'(i), 1'b1);
      end
      expect_beat(2'd1, 8'h11); expect_beat(2'd2, 8'h12);
      expect_beat(2'd3, 8'h13); expect_beat(2'd0, 8'h10);
      expect_beat(2'd1, 8'h21); expect_beat(2'd2, 8'h22);
      expect_beat(2'd3, 8'h23); expect_beat(2'd0, 8'h20);
      wait_drain("t2", 100);
      check("t2_beats", 32'(beat_cyc.size()), 32'd8);
      if (beat_cyc.size() == 8) check("t2_spacing", 32'(beat_cyc[7] - beat_cyc[0]), 32'd14);

      // 3) burst cap of 4: source 0 is preempted by source 2 and resumes in order
      @(negedge clk);
      for (int i = 0; i < 12; i++) load(0, 8'h30 + 8'(i), 1'b0);
      for (int i = 0; i < 4; i++) expect_beat(2'd0, 8'h30 + 8'(i));
      expect_beat(2'd2, 8'hC0); expect_beat(2'd2, 8'hC1); expect_beat(2'd2, 8'hC2);
      for (int i = 4; i < 12; i++) expect_beat(2'd0, 8'h30 + 8'(i));
      repeat (2) @(negedge clk);
      load(2, 8'hC0, 1'b0); load(2, 8'hC1, 1'b0); load(2, 8'hC2, 1'b1);
      wait_drain("t3", 200);

      // 4) sink stall mid-packet; last byte coincides with the burst cap
      load(1, 8'hD0, 1'b0); load(1, 8'hD1, 1'b0); load(1, 8'hD2, 1'b0); load(1, 8'hD3, 1'b1);
      expect_beat(2'd1, 8'hD0); expect_beat(2'd1, 8'hD1);
      expect_beat(2'd1, 8'hD2); expect_beat(2'd1, 8'hD3);
      wait_tx("t4_d1", 8'hD1, 50);
      @(posedge clk); #1; tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t4_stall_data", 32'(tx_data), 32'hD2);
         check("t4_stall_valid", 32'(tx_valid), 32'd1);
         check("t4_stall_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1; tx_ready = 1'b1;
      wait_drain("t4", 50);
      check("t4_released", 32'(grant_active), 32'd0);

      // 6) reset while byte 2 of source 3 is presented
      load(3, 8'hE0, 1'b0); load(3, 8'hE1, 1'b0); load(3, 8'hE2, 1'b1);
      expect_beat(2'd3, 8'hE0);
      wait_tx("t6_e0", 8'hE0, 50);
      @(posedge clk); #1; rst = 1'b1;
      @(negedge clk);
      check("t6_rst_cycle_valid", 32'(tx_valid), 32'd0);
      check("t6_rst_cycle_ready", 32'(req_ready), 32'd0);
      load(0, 8'hF0, 1'b1);
      expect_beat(2'd0, 8'hF0); expect_beat(2'd3, 8'hE1); expect_beat(2'd3, 8'hE2);
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check("t6_post_valid", 32'(tx_valid), 32'd0);
      check("t6_post_active", 32'(grant_active), 32'd0);
      check("t6_post_grant_id", 32'(grant_id), 32'd0);
      check("t6_post_ready", 32'(req_ready), 32'd0);
      check("t6_post_data", 32'(tx_data), 32'd0);
      wait_drain("t6", 50);

      // 5) GAP_CYCLES=3: XFER, 3 GAP, 1 IDLE, XFER ...
      ga_pat = 12'b1000_0100_0010;
      @(posedge clk); #1;
      req_valid2 = 4'b0001; req_data2 = 32'h0000_0055; req_last2 = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         check("t5_grant_active", 32'(grant_active2), 32'(ga_pat[k]));
         if (ga_pat[k]) begin
            check("t5_tx_valid", 32'(tx_valid2), 32'd1);
            check("t5_tx_data", 32'(tx_data2), 32'h55);
            check("t5_grant_id", 32'(grant_id2), 32'd0);
         end
      end
      @(posedge clk); #1; req_valid2 = '0; req_last2 = '0;

      @(negedge clk);
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
